// File: rtl/dense_loader_pkg.sv
// dense_loader_pkg: shared word type, FSM states, default geometry and word-count helper for the dense weight loader
package dense_loader_pkg;
  localparam int DL_N_IN  = 32;
  localparam int DL_N_OUT = 5;
  localparam int DL_WIDTH = 19;
  localparam int DL_NFRAC = 10;
  typedef logic signed [DL_WIDTH-1:0] word_t;
  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_B, CHECK, COMMIT} state_t;
  function automatic int n_words(input int n_in, input int n_out, input int chk);
    return n_in * n_out + n_out + chk;
  endfunction
endpackage

// File: rtl/dense_weight_bank.sv
// dense_weight_bank: shadow bank filled word by word, copied whole into the live bank on a commit strobe
module dense_weight_bank
  import dense_loader_pkg::*;
#(
  parameter int N_IN  = DL_N_IN,
  parameter int N_OUT = DL_N_OUT,
  parameter int WIDTH = DL_WIDTH,
  parameter int RW    = 5,
  parameter int CW    = 3
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  i_we,
  input  logic                                  i_bsel,
  input  logic [RW-1:0]                         i_row,
  input  logic [CW-1:0]                         i_col,
  input  logic [WIDTH-1:0]                      i_data,
  input  logic                                  i_commit,
  output logic [N_IN-1:0][N_OUT-1:0][WIDTH-1:0] o_w,
  output logic [N_OUT-1:0][WIDTH-1:0]           o_b
);
  logic [N_IN-1:0][N_OUT-1:0][WIDTH-1:0] r_sw, r_lw;
  logic [N_OUT-1:0][WIDTH-1:0]           r_sb, r_lb;
  // stream words land in the shadow; the live bank moves only on commit
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sw <= '0;
      r_lw <= '0;
      r_sb <= '0;
      r_lb <= '0;
    end else begin
      if (i_we && !i_bsel) r_sw[i_row][i_col] <= i_data;
      if (i_we && i_bsel) r_sb[i_col] <= i_data;
      if (i_commit) begin
        r_lw <= r_sw;
        r_lb <= r_sb;
      end
    end
  end
  assign o_w = r_lw;
  assign o_b = r_lb;
endmodule

// File: rtl/dense_weight_loader.sv
// dense_weight_loader: serial loader of dense-layer weights then biases with atomic commit; DENSE_LOADER_CHECKSUM_EN adds a trailing checksum word
module dense_weight_loader
  import dense_loader_pkg::*;
#(
  parameter int N_IN  = DL_N_IN,
  parameter int N_OUT = DL_N_OUT,
  parameter int WIDTH = DL_WIDTH,
  parameter int NFRAC = DL_NFRAC
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  logic [WIDTH-1:0]                      s_data,
  input  logic                                  s_last,
  output logic [N_IN-1:0][N_OUT-1:0][WIDTH-1:0] weights_o,
  output logic [N_OUT-1:0][WIDTH-1:0]           bias_o,
  output logic                                  loaded,
  output logic                                  busy,
  output logic                                  error
);
`ifdef DENSE_LOADER_CHECKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif
  localparam int N_WORDS = n_words(N_IN, N_OUT, CHK);
  localparam int NW      = N_IN * N_OUT;
  localparam int CNTW    = $clog2(N_WORDS);
  localparam int RW      = N_IN > 1 ? $clog2(N_IN) : 1;
  localparam int CW      = N_OUT > 1 ? $clog2(N_OUT) : 1;
  if (NFRAC >= WIDTH) begin : g_nfrac_range
    logic w_nfrac_out_of_range;
    assign w_nfrac_out_of_range = 1'b1;
  end
  state_t          r_state, w_next;
  logic [CNTW-1:0] r_cnt;
  logic [RW-1:0]   r_row;
  logic [CW-1:0]   r_col;
  logic            r_error, r_loaded, r_pend;
  logic            w_loading, w_acc, w_final, w_go, w_clear, w_fail, w_sum_bad, w_col_wrap;
  assign w_loading  = r_state inside {LOAD_W, LOAD_B, CHECK};
  assign s_ready    = w_loading;
  assign w_acc      = s_valid && w_loading && !start;
  assign w_final    = r_cnt == CNTW'(N_WORDS - 1);
  assign w_go       = start || r_pend;
  assign w_clear    = w_go && r_state != COMMIT;
  assign w_col_wrap = r_col == CW'(N_OUT - 1);
  assign w_fail     = w_acc && (s_last != w_final || (r_state == CHECK && w_sum_bad));
  assign busy       = r_state != IDLE;
  assign loaded     = r_loaded;
  assign error      = r_error;
  // state register
  always_ff @(posedge clk) begin
    r_state <= reset ? IDLE : w_next;
  end
  // next state: start restarts any load, a framing or checksum fault drops to IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_go ? LOAD_W : IDLE;
      LOAD_W:  w_next = start ? LOAD_W : w_fail ? IDLE : (w_acc && r_cnt == CNTW'(NW - 1)) ? LOAD_B : LOAD_W;
      LOAD_B:  w_next = start ? LOAD_W : w_fail ? IDLE : (w_acc && w_col_wrap) ? (CHK != 0 ? CHECK : COMMIT) : LOAD_B;
      CHECK:   w_next = start ? LOAD_W : w_fail ? IDLE : w_acc ? COMMIT : CHECK;
      COMMIT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // word index plus row/column position; column doubles as the bias index
  always_ff @(posedge clk) begin
    if (reset || w_clear) begin
      r_cnt <= '0;
      r_row <= '0;
      r_col <= '0;
    end else if (w_acc) begin
      r_cnt <= r_cnt + 1'b1;
      r_col <= w_col_wrap ? '0 : r_col + 1'b1;
      r_row <= (r_state == LOAD_W && w_col_wrap) ? r_row + 1'b1 : r_row;
    end
  end
  // sticky error, loaded flag, and a start seen during COMMIT held for one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_error  <= 1'b0;
      r_loaded <= 1'b0;
      r_pend   <= 1'b0;
    end else begin
      r_error  <= w_clear ? 1'b0 : w_fail ? 1'b1 : r_error;
      r_loaded <= r_state == COMMIT ? 1'b1 : r_loaded;
      r_pend   <= start && r_state == COMMIT;
    end
  end
`ifdef DENSE_LOADER_CHECKSUM_EN
  logic [WIDTH-1:0] r_sum;
  // running mod-2^WIDTH sum of every weight and bias word of the current load
  always_ff @(posedge clk) begin
    if (reset || w_clear) r_sum <= '0;
    else if (w_acc && r_state != CHECK) r_sum <= r_sum + s_data;
  end
  assign w_sum_bad = s_data != r_sum;
`else
  assign w_sum_bad = 1'b0;
`endif
  dense_weight_bank #(
    .N_IN (N_IN),
    .N_OUT(N_OUT),
    .WIDTH(WIDTH),
    .RW   (RW),
    .CW   (CW)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_acc && r_state != CHECK),
    .i_bsel  (r_state == LOAD_B),
    .i_row   (r_row),
    .i_col   (r_col),
    .i_data  (s_data),
    .i_commit(r_state == COMMIT),
    .o_w     (weights_o),
    .o_b     (bias_o)
  );
endmodule

// File: doc/dense_weight_loader.md
# dense_weight_loader

Runtime writer for dense-layer parameters: accepts a serial stream of signed fixed-point words (weights row-major, then biases), fills a shadow bank, and commits it atomically to a live bank read combinationally by the dense layer. It replaces compile-time constant weight packages when parameters must be reloaded without resynthesis, and sits between the host/config stream and a dense layer instance such as the 32x5, 19-bit/10-frac layer.

## Interface
- N_IN, 32, dense layer input count (weight rows)
- N_OUT, 5, dense layer output count (weight columns, bias count)
- WIDTH, 19, word width, signed two's complement
- NFRAC, 10, fractional bits; informational only, no arithmetic depends on it
- clk  in  1  single clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- start  in  1  begin (or restart) a load; single-cycle pulse
- s_valid  in  1  stream word valid
- s_ready  out  1  stream word accepted when s_valid && s_ready
- s_data  in  WIDTH  stream word
- s_last  in  1  marks final word of a load
- weights_o  out  [N_IN][N_OUT] x WIDTH  live weight bank
- bias_o  out  [N_OUT] x WIDTH  live bias bank
- loaded  out  1  live bank holds a committed load
- busy  out  1  load in progress
- error  out  1  sticky; last load aborted; cleared by start or reset

## Operation
- States: IDLE, LOAD_W, LOAD_B, CHECK (only with checksum), COMMIT.
- IDLE: s_ready=0; start -> LOAD_W, counters cleared, error cleared.
- LOAD_W: s_ready=1; each accepted word writes shadow_w[row][col]; col increments, wraps at N_OUT-1 to 0 with row+1; after word N_IN*N_OUT-1 -> LOAD_B.
- LOAD_B: s_ready=1; word k writes shadow_b[k]; after k=N_OUT-1 -> COMMIT (or CHECK).
- Total words N_WORDS = N_IN*N_OUT + N_OUT (165 default; 166 with checksum).
- s_last must be high exactly on word N_WORDS-1. s_last on an earlier word, or low on the final word: error=1, -> IDLE, live bank untouched.
- COMMIT: one cycle; shadow copied to live bank, loaded=1, -> IDLE.
- start during LOAD_*/CHECK: abort, counters cleared, stay loading from word 0; shadow contents discarded; error unchanged by the abort itself (cleared by start).
- start while in COMMIT: commit completes, start honoured next cycle.
- Live bank changes only in COMMIT; dense layer never sees a partial set.

## Timing
- Reset values: s_ready=0, busy=0, loaded=0, error=0, weights_o and bias_o all zero, state IDLE.
- start at cycle t -> s_ready=1 at t+1.
- Throughput one word per cycle; s_valid may drop at any time, no timeout.
- Final word accepted at t -> live bank and loaded updated at t+2 (t+1 COMMIT registers copy, outputs visible t+2 ... precisely: COMMIT state at t+1, registered outputs valid t+2).
- busy=1 in every state except IDLE.
- Reset mid-load: immediate return to reset values including live bank and loaded.

## Configuration
- DENSE_LOADER_CHECKSUM_EN defined: one extra word after biases; must equal the mod-2^WIDTH sum of all preceding words of the load; mismatch -> error=1, no commit. s_last expected on this word.
- Undefined: no CHECK state, N_WORDS excludes checksum, no sum logic.

## Structure
- Package dense_loader_pkg: word_t (logic signed [WIDTH-1:0]), state enum, N_WORDS localparam helper function.
- Sub-module dense_weight_bank: shadow + live arrays, write port (row, col/bias select, data), commit strobe, reset clear. FSM and counters stay in top.

## Test plan
- Reset, then stream 165 words value = index, s_last on 165th -> weights_o[0][0]=0, weights_o[31][4]=159, bias_o[4]=164, loaded=1 two cycles after last.
- Same stream with s_valid toggling every other cycle -> identical bank; busy held through.
- s_last on word 100 -> error=1, IDLE, live bank still holds previous load, loaded unchanged.
- start asserted after word 50, then full 165-word load of all 19'h7FC00 (-1.0) -> all live entries 19'h7FC00, error=0.
- Checksum enabled: 165 words of 1 plus checksum 165 -> commit; checksum 164 -> error=1, no commit.
- Reset asserted mid-LOAD_B after a prior committed load -> all outputs zero, loaded=0 next cycle.
